// File: rtl/loopback_pkg.sv
// Shared types and constants for the loopback traffic checker: generator
// state encoding, seed base and the Galois LFSR feedback masks per beat width.
package loopback_pkg;

  typedef enum logic [1:0] {
    GEN_DOWN = 2'd0,
    GEN_SEND = 2'd1,
    GEN_GAP  = 2'd2
  } gen_state_e;

  // Per-channel seed is SEED_BASE+ch+1; the low 16 bits are non-zero for any
  // realistic channel count, so no width ever truncates a seed to all-zero.
  localparam logic [63:0] SEED_BASE = 64'h0000_0000_1357_9BD0;

  // Right-shifting Galois masks of maximal-length polynomials.
  localparam logic [63:0] POLY_W16 = 64'h0000_0000_0000_B400;
  localparam logic [63:0] POLY_W32 = 64'h0000_0000_8020_0003;
  localparam logic [63:0] POLY_W64 = 64'hD800_0000_0000_0000;

  function automatic logic [63:0] lfsr_poly(input int width);
    case (width)
      16:      return POLY_W16;
      32:      return POLY_W32;
      64:      return POLY_W64;
      default: return 64'd0;
    endcase
  endfunction

  // One Galois step; the caller keeps bits above 'width' at zero.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s, input int width);
    logic [63:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ lfsr_poly(width);
    return n;
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Galois PRBS register. Load takes priority over step; the reset value is a
// parameter so a data-dependent load seed can never leak into reset.
import loopback_pkg::*;

module prbs_lfsr #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q, state_d;

  // Next state: reload, advance by one step, or hold.
  always_comb begin
    state_d = state_q;
    if (load)      state_d = seed;
    else if (step) state_d = W'(lfsr_next(64'(state_q), W));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RST_VAL;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/loopback_traffic_checker.sv
// Per-channel PRBS frame generator plus receive checker with saturating
// error counter and link-verified flag.
// Build option: define CHECKER_RESYNC_EN to let the checker re-seed its
// expected sequence from the received data after a data error.
//
// Generator states:
//   state    | meaning
//   GEN_DOWN | link down, tx idle, LFSR held at seed, beat index 0
//   GEN_SEND | tx_tvalid high, LFSR/index advance on each accepted beat
//   GEN_GAP  | one idle cycle after the tlast beat
import loopback_pkg::*;

module loopback_traffic_checker #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 16,
  parameter int ERR_W     = 4
) (
  input  logic                     clk,
  input  logic                     peripheral_reset,
  input  logic [NUM_CH-1:0]        channel_up,
  output logic [NUM_CH*DATA_W-1:0] tx_tdata,
  output logic [NUM_CH-1:0]        tx_tvalid,
  output logic [NUM_CH-1:0]        tx_tlast,
  input  logic [NUM_CH-1:0]        tx_tready,
  input  logic [NUM_CH*DATA_W-1:0] rx_tdata,
  input  logic [NUM_CH-1:0]        rx_tvalid,
  input  logic [NUM_CH-1:0]        rx_tlast,
  input  logic                     err_clear,
  output logic [NUM_CH*ERR_W-1:0]  error_count,
  output logic [NUM_CH-1:0]        rx_lock
);

  localparam int               IDX_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  if (DATA_W != 16 && DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("loopback_traffic_checker: DATA_W must be 16, 32 or 64");
  end
  if (FRAME_LEN < 2 || FRAME_LEN > 256) begin : g_bad_frame_len
    $error("loopback_traffic_checker: FRAME_LEN must be within 2..256");
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    localparam logic [DATA_W-1:0] SEED = DATA_W'(SEED_BASE + 64'(ch) + 64'd1);

    // ---------------- generator ----------------
    gen_state_e       gen_state_q, gen_state_d;
    logic [IDX_W-1:0] gen_idx_q, gen_idx_d;
    logic [DATA_W-1:0] gen_lfsr;
    logic gen_send, gen_last, gen_fire;

    assign gen_send = (gen_state_q == GEN_SEND);
    assign gen_last = (gen_idx_q == LAST_IDX);
    assign gen_fire = gen_send & tx_tready[ch];

    // Generator FSM and beat index; link loss overrides everything.
    always_comb begin
      gen_state_d = gen_state_q;
      gen_idx_d   = gen_idx_q;
      if (!channel_up[ch]) begin
        gen_state_d = GEN_DOWN;
        gen_idx_d   = '0;
      end else begin
        case (gen_state_q)
          GEN_DOWN: gen_state_d = GEN_SEND;
          GEN_SEND: begin
            if (tx_tready[ch]) begin
              if (gen_last) begin
                gen_state_d = GEN_GAP;
                gen_idx_d   = '0;
              end else begin
                gen_idx_d = gen_idx_q + IDX_W'(1);
              end
            end
          end
          GEN_GAP:  gen_state_d = GEN_SEND;
          default:  gen_state_d = GEN_DOWN;
        endcase
      end
    end

    // Generator state registers.
    always_ff @(posedge clk or posedge peripheral_reset) begin
      if (peripheral_reset) begin
        gen_state_q <= GEN_DOWN;
        gen_idx_q   <= '0;
      end else begin
        gen_state_q <= gen_state_d;
        gen_idx_q   <= gen_idx_d;
      end
    end

    prbs_lfsr #(.W(DATA_W), .RST_VAL(SEED)) u_gen_lfsr (
      .clk   (clk),
      .rst   (peripheral_reset),
      .load  (!channel_up[ch]),
      .seed  (SEED),
      .step  (gen_fire),
      .state (gen_lfsr)
    );

    assign tx_tvalid[ch]                = gen_send;
    assign tx_tlast[ch]                 = gen_send & gen_last;
    assign tx_tdata[ch*DATA_W +: DATA_W] = gen_send ? gen_lfsr : '0;

    // ---------------- checker ----------------
    logic [DATA_W-1:0] chk_exp, rx_data, chk_seed;
    logic [IDX_W-1:0]  chk_idx_q, chk_idx_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic chk_clean_q, chk_clean_d, lock_q, lock_d;
    logic chk_beat, chk_last, data_err, beat_err, resync;

    assign rx_data  = rx_tdata[ch*DATA_W +: DATA_W];
    assign chk_beat = rx_tvalid[ch] & channel_up[ch];
    assign chk_last = (chk_idx_q == LAST_IDX);
    assign data_err = chk_beat && (rx_data != chk_exp);
    assign beat_err = data_err | (chk_beat && (rx_tlast[ch] != chk_last));

`ifdef CHECKER_RESYNC_EN
    assign resync   = data_err;
    assign chk_seed = channel_up[ch] ? DATA_W'(lfsr_next(64'(rx_data), DATA_W)) : SEED;
`else
    assign resync   = 1'b0;
    assign chk_seed = SEED;
`endif

    prbs_lfsr #(.W(DATA_W), .RST_VAL(SEED)) u_chk_lfsr (
      .clk   (clk),
      .rst   (peripheral_reset),
      .load  (!channel_up[ch] | resync),
      .seed  (chk_seed),
      .step  (chk_beat),
      .state (chk_exp)
    );

    // Beat index and frame cleanliness; lock is judged at each frame's last beat.
    always_comb begin
      chk_idx_d   = chk_idx_q;
      chk_clean_d = chk_clean_q;
      lock_d      = lock_q;
      if (!channel_up[ch]) begin
        chk_idx_d   = '0;
        chk_clean_d = 1'b1;
        lock_d      = 1'b0;
      end else if (chk_beat) begin
        chk_idx_d = chk_last ? '0 : chk_idx_q + IDX_W'(1);
        if (chk_last) begin
          lock_d      = chk_clean_q & ~beat_err;
          chk_clean_d = 1'b1;
        end else if (beat_err) begin
          lock_d      = 1'b0;
          chk_clean_d = 1'b0;
        end
      end
    end

    // Saturating error counter; clear wins over a coincident error and the
    // count deliberately survives link loss.
    always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clear)                            err_cnt_d = '0;
      else if (beat_err && err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    // Checker registers.
    always_ff @(posedge clk or posedge peripheral_reset) begin
      if (peripheral_reset) begin
        chk_idx_q   <= '0;
        chk_clean_q <= 1'b1;
        lock_q      <= 1'b0;
        err_cnt_q   <= '0;
      end else begin
        chk_idx_q   <= chk_idx_d;
        chk_clean_q <= chk_clean_d;
        lock_q      <= lock_d;
        err_cnt_q   <= err_cnt_d;
      end
    end

    assign error_count[ch*ERR_W +: ERR_W] = err_cnt_q;
    assign rx_lock[ch]                    = lock_q;
  end

endmodule

// File: tb/tb_loopback_traffic_checker.sv
// Loopback bench: tx is wired back to rx through an XOR corruption mask.
// A behavioural model (reference PRBS built from polynomial tap exponents,
// beat counters per frame) predicts tx beats, error counts and lock.
module tb_loopback_traffic_checker;
  import loopback_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 32;
  localparam int FRAME_LEN = 16;
  localparam int ERR_W     = 4;
  localparam int ERR_MAX   = (1 << ERR_W) - 1;
  localparam int FRAME_CYC = FRAME_LEN + 1;
`ifdef CHECKER_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic clk = 1'b0;
  logic peripheral_reset, err_clear;
  logic [NUM_CH-1:0] channel_up, tx_tready, tx_tvalid, tx_tlast;
  logic [NUM_CH-1:0] rx_tvalid, rx_tlast, rx_lock, corrupt_last;
  logic [NUM_CH*DATA_W-1:0] tx_tdata, rx_tdata, corrupt_data;
  logic [NUM_CH*ERR_W-1:0] error_count;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [DATA_W-1:0] gval [NUM_CH];
  logic [DATA_W-1:0] cexp [NUM_CH];
  int gcnt [NUM_CH];
  int cn   [NUM_CH];
  int mcnt [NUM_CH];
  bit vexp [NUM_CH];
  bit cbad [NUM_CH];
  bit mlock[NUM_CH];

  assign rx_tvalid = tx_tvalid & tx_tready;
  assign rx_tdata  = tx_tdata ^ corrupt_data;
  assign rx_tlast  = tx_tlast ^ corrupt_last;

  loopback_traffic_checker #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ERR_W(ERR_W)
  ) dut (
    .clk(clk), .peripheral_reset(peripheral_reset), .channel_up(channel_up),
    .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
    .tx_tready(tx_tready), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid),
    .rx_tlast(rx_tlast), .err_clear(err_clear), .error_count(error_count),
    .rx_lock(rx_lock)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference PRBS step, mask assembled from the polynomial's tap exponents.
  function automatic logic [DATA_W-1:0] ref_step(input logic [DATA_W-1:0] s);
    logic [DATA_W-1:0] m;
    int taps[4];
    m = '0;
    case (DATA_W)
      16:      taps = '{16, 14, 13, 11};
      32:      taps = '{32, 22, 2, 1};
      default: taps = '{64, 63, 61, 60};
    endcase
    foreach (taps[i]) m[taps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ m) : (s >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] seed_of(input int ch);
    return DATA_W'(SEED_BASE + 64'(ch) + 64'd1);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      gval[ch] = seed_of(ch); gcnt[ch] = 0; vexp[ch] = 1'b0;
      cexp[ch] = seed_of(ch); cn[ch] = 0; cbad[ch] = 1'b0;
      mlock[ch] = 1'b0; mcnt[ch] = 0;
    end
  endtask

  // Advance the model across the coming rising edge using the settled inputs.
  task automatic model_update();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit err, derr, islast, fire;
      logic [DATA_W-1:0] rd;
      err  = 1'b0;
      fire = vexp[ch] && tx_tready[ch];
      if (!channel_up[ch]) begin
        gval[ch] = seed_of(ch); gcnt[ch] = 0; vexp[ch] = 1'b0;
        cexp[ch] = seed_of(ch); cn[ch] = 0; cbad[ch] = 1'b0; mlock[ch] = 1'b0;
      end else begin
        if (fire) begin
          islast = (gcnt[ch] % FRAME_LEN) == FRAME_LEN - 1;
          check($sformatf("tdata[%0d]", ch), tx_tdata[ch*DATA_W +: DATA_W], gval[ch]);
          check($sformatf("tlast[%0d]", ch), tx_tlast[ch], islast);
          gval[ch] = ref_step(gval[ch]);
          gcnt[ch]++;
          vexp[ch] = !islast;
        end else if (!vexp[ch]) begin
          vexp[ch] = 1'b1;
        end
        if (rx_tvalid[ch]) begin
          rd     = rx_tdata[ch*DATA_W +: DATA_W];
          islast = (cn[ch] == FRAME_LEN - 1);
          derr   = (rd != cexp[ch]);
          err    = derr || (rx_tlast[ch] != islast);
          if (err) cbad[ch] = 1'b1;
          if (islast) begin
            mlock[ch] = !cbad[ch];
            cbad[ch]  = 1'b0;
          end else if (err) begin
            mlock[ch] = 1'b0;
          end
          cexp[ch] = (RESYNC && derr) ? ref_step(rd) : ref_step(cexp[ch]);
          cn[ch]   = islast ? 0 : cn[ch] + 1;
        end
      end
      if (err_clear)                     mcnt[ch] = 0;
      else if (err && mcnt[ch] < ERR_MAX) mcnt[ch]++;
    end
  endtask

  task automatic check_outputs();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check($sformatf("tvalid[%0d]", ch), tx_tvalid[ch], vexp[ch]);
      check($sformatf("errcnt[%0d]", ch), error_count[ch*ERR_W +: ERR_W], mcnt[ch]);
      check($sformatf("lock[%0d]", ch), rx_lock[ch], mlock[ch]);
      if (peripheral_reset) begin
        check($sformatf("rst_tlast[%0d]", ch), tx_tlast[ch], 0);
        check($sformatf("rst_tdata[%0d]", ch), tx_tdata[ch*DATA_W +: DATA_W], 0);
      end
    end
  endtask

  // Called right after a falling edge with the next inputs already driven.
  task automatic step_cycle();
    #1;
    if (peripheral_reset) model_reset();
    else                  model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) step_cycle();
  endtask

  task automatic clear_pulse();
    err_clear = 1'b1;
    step_cycle();
    err_clear = 1'b0;
    for (int ch = 0; ch < NUM_CH; ch++)
      check($sformatf("clr_cnt[%0d]", ch), error_count[ch*ERR_W +: ERR_W], 0);
  endtask

  initial begin
    int target, b, saved;
    peripheral_reset = 1'b1; err_clear = 1'b0;
    channel_up = '0; tx_tready = '0; corrupt_data = '0; corrupt_last = '0;
    model_reset();
    @(negedge clk);
    run(3);

    // clean loopback, 100 frames on every channel
    peripheral_reset = 1'b0; channel_up = '1; tx_tready = '1;
    run(100 * FRAME_CYC + 2);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check($sformatf("clean_cnt[%0d]", ch), error_count[ch*ERR_W +: ERR_W], 0);
      check($sformatf("clean_lock[%0d]", ch), rx_lock[ch], 1);
      check($sformatf("clean_beats[%0d]", ch), gcnt[ch] >= 100 * FRAME_LEN, 1);
    end

    // isolated bit-0 flip on beat 5 of the third frame from here, channel 0
    target = (gcnt[0] / FRAME_LEN + 3) * FRAME_LEN + 5;
    b = 0;
    while (gcnt[0] <= target && b < 200) begin
      corrupt_data[0] = (gcnt[0] == target);
      step_cycle();
      b++;
    end
    corrupt_data = '0;
    check("iso_reach", gcnt[0] > target, 1);
    check("iso_cnt", error_count[0 +: ERR_W], 1);
    check("iso_lock", rx_lock[0], 0);
    run(4 * FRAME_CYC);
    clear_pulse();

    // twenty consecutive corrupt beats on channel 1 saturate the counter
    target = gcnt[1] + 2;
    b = 0;
    while (gcnt[1] < target + 20 && b < 200) begin
      corrupt_data[DATA_W] = (gcnt[1] >= target);
      step_cycle();
      b++;
    end
    corrupt_data = '0;
    check("sat_reach", gcnt[1] >= target + 20, 1);
    check("sat_cnt", error_count[ERR_W +: ERR_W], ERR_MAX);
    run(20);
    check("sat_hold", error_count[ERR_W +: ERR_W], ERR_MAX);
    clear_pulse();

    // clear coincident with an erroneous beat on channel 1
    b = 0;
    while (!vexp[1] && b < 10) begin step_cycle(); b++; end
    check("coinc_valid", tx_tvalid[1], 1);
    corrupt_data[DATA_W] = 1'b1; err_clear = 1'b1;
    step_cycle();
    corrupt_data = '0; err_clear = 1'b0;
    check("coinc_cnt", error_count[ERR_W +: ERR_W], 0);

    // data and tlast wrong on the same beat count once, channel 0
    b = 0;
    while (!vexp[0] && b < 10) begin step_cycle(); b++; end
    corrupt_data[0] = 1'b1; corrupt_last[0] = 1'b1;
    step_cycle();
    corrupt_data = '0; corrupt_last = '0;
    check("dual_cnt", error_count[0 +: ERR_W], 1);
    run(3 * FRAME_CYC);
    clear_pulse();

    // random back-pressure, about 50% duty on each channel
    repeat (2000) begin
      tx_tready = NUM_CH'($urandom);
      step_cycle();
    end
    tx_tready = '1;
    run(2 * FRAME_CYC + 2);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check($sformatf("rnd_cnt[%0d]", ch), error_count[ch*ERR_W +: ERR_W], 0);
      check($sformatf("rnd_lock[%0d]", ch), rx_lock[ch], 1);
    end

    // channel 2 link drop for 10 cycles mid-frame
    b = 0;
    while (!((gcnt[2] % FRAME_LEN) == 7 && vexp[2]) && b < 40) begin step_cycle(); b++; end
    check("drop_reach", gcnt[2] % FRAME_LEN, 7);
    saved = mcnt[2];
    channel_up[2] = 1'b0;
    run(10);
    check("drop_valid", tx_tvalid[2], 0);
    check("drop_lock", rx_lock[2], 0);
    check("drop_cnt", error_count[2*ERR_W +: ERR_W], saved);
    channel_up[2] = 1'b1;
    run(3 * FRAME_CYC + 2);
    check("drop_relock", rx_lock[2], 1);
    check("drop_recnt", error_count[2*ERR_W +: ERR_W], saved);

    // asynchronous reset mid-frame
    b = 0;
    while ((gcnt[3] % FRAME_LEN) != 9 && b < 40) begin step_cycle(); b++; end
    check("rst_reach", gcnt[3] % FRAME_LEN, 9);
    peripheral_reset = 1'b1;
    #1;
    check("rst_async_valid", tx_tvalid, 0);
    check("rst_async_lock", rx_lock, 0);
    run(2);
    peripheral_reset = 1'b0;
    run(3 * FRAME_CYC + 2);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      check($sformatf("rst_relock[%0d]", ch), rx_lock[ch], 1);
      check($sformatf("rst_cnt[%0d]", ch), error_count[ch*ERR_W +: ERR_W], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
